// File: rtl/ls_regfile.sv
// rtl/ls_regfile.sv - 2**a x n register file, one write port, two registered read ports with bypass
module ls_regfile #(
    parameter int n       = 4,
    parameter int a       = 2,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         we,
    input  logic [a-1:0] waddr,
    input  logic [n-1:0] win,
    input  logic [a-1:0] ra,
    input  logic [a-1:0] rb,
    output logic [n-1:0] outa,
    output logic [n-1:0] outb,
    output logic         va,
    output logic         vb
);
    localparam int DEPTH = 1 << a;

    logic [n-1:0]     mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic             wr_ok;
    logic [n:0]       rd_a;
    logic [n:0]       rd_b;

    // Entry 0 is never written when hardwired, so mem[0]/valid[0] stay cleared.
    assign wr_ok = we && !(ZERO_R0 && (waddr == '0));

    // Read priority: hardwired zero, then same-cycle write data, then stored entry.
    always_comb begin
        rd_a = {valid[ra], mem[ra]};
        if (we && (waddr == ra))
            rd_a = {1'b1, win};
        if (ZERO_R0 && (ra == '0))
            rd_a = {1'b1, {n{1'b0}}};
    end

    always_comb begin
        rd_b = {valid[rb], mem[rb]};
        if (we && (waddr == rb))
            rd_b = {1'b1, win};
        if (ZERO_R0 && (rb == '0))
            rd_b = {1'b1, {n{1'b0}}};
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            valid <= '0;
            outa  <= '0;
            outb  <= '0;
            va    <= 1'b0;
            vb    <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem[waddr]   <= win;
                valid[waddr] <= 1'b1;
            end
            outa <= rd_a[n-1:0];
            va   <= rd_a[n];
            outb <= rd_b[n-1:0];
            vb   <= rd_b[n];
        end
    end
endmodule

// File: tb/tb_ls_regfile.sv
// tb/tb_ls_regfile.sv - scoreboard bench for ls_regfile (default, ZERO_R0 and 16x16 instances)
module tb_ls_regfile;
    logic        clk = 1'b0;
    logic        clr;
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] win;
    logic [3:0]  ra;
    logic [3:0]  rb;

    logic [3:0]  d_outa, d_outb, z_outa, z_outb;
    logic [15:0] w_outa, w_outb;
    logic        d_va, d_vb, z_va, z_vb, w_va, w_vb;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        int          dut;
        bit          ca;
        logic [15:0] ea;
        logic        eva;
        bit          cb;
        logic [15:0] eb;
        logic        evb;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    ls_regfile #(.n(4), .a(2), .ZERO_R0(1'b0)) u_d (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr[1:0]), .win(win[3:0]),
        .ra(ra[1:0]), .rb(rb[1:0]), .outa(d_outa), .outb(d_outb), .va(d_va), .vb(d_vb)
    );
    ls_regfile #(.n(4), .a(2), .ZERO_R0(1'b1)) u_z (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr[1:0]), .win(win[3:0]),
        .ra(ra[1:0]), .rb(rb[1:0]), .outa(z_outa), .outb(z_outb), .va(z_va), .vb(z_vb)
    );
    ls_regfile #(.n(16), .a(4), .ZERO_R0(1'b0)) u_w (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr), .win(win),
        .ra(ra), .rb(rb), .outa(w_outa), .outb(w_outb), .va(w_va), .vb(w_vb)
    );

    function automatic logic [16:0] port_a(input int dut);
        case (dut)
            0:       return {d_va, 12'h000, d_outa};
            1:       return {z_va, 12'h000, z_outa};
            default: return {w_va, w_outa};
        endcase
    endfunction

    function automatic logic [16:0] port_b(input int dut);
        case (dut)
            0:       return {d_vb, 12'h000, d_outb};
            1:       return {z_vb, 12'h000, z_outb};
            default: return {w_vb, w_outb};
        endcase
    endfunction

    task automatic compare(input string nm, input logic [16:0] act, input logic [16:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got data=%h valid=%b, expected data=%h valid=%b",
                     nm, act[15:0], act[16], exp[15:0], exp[16]);
        end
    endtask

    // Monitor: one expected record per checked edge, compared just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.ca) compare({e.name, ".A"}, port_a(e.dut), {e.eva, e.ea});
                if (e.cb) compare({e.name, ".B"}, port_b(e.dut), {e.evb, e.eb});
            end
        end
    end

    task automatic cyc(input string nm, input int dut,
                       input bit ca, input logic [15:0] ea, input logic eva,
                       input bit cb, input logic [15:0] eb, input logic evb);
        exp_t e;
        e.name = nm; e.dut = dut;
        e.ca = ca; e.ea = ea; e.eva = eva;
        e.cb = cb; e.eb = eb; e.evb = evb;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic w, input logic [3:0] wa, input logic [15:0] wd,
                         input logic [3:0] a_addr, input logic [3:0] b_addr);
        we = w; waddr = wa; win = wd; ra = a_addr; rb = b_addr;
    endtask

    logic [3:0] fillv [4];

    initial begin
        clr = 1'b0;
        drive(1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
        @(negedge clk);
        compare("reset_d_a", port_a(0), 17'h0);
        compare("reset_d_b", port_b(0), 17'h0);
        compare("reset_w_a", port_a(2), 17'h0);
        clr = 1'b1;

        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'd0, 16'h0, 4'(i), 4'(3 - i));
            cyc($sformatf("sweep_unwritten_%0d", i), 0, 1, 16'h0, 1'b0, 1, 16'h0, 1'b0);
        end

        drive(1'b1, 4'd2, 16'h000A, 4'd0, 4'd0);
        cyc("write2_read0", 0, 1, 16'h0, 1'b0, 1, 16'h0, 1'b0);
        drive(1'b0, 4'd0, 16'h0, 4'd2, 4'd2);
        cyc("read2_latency", 0, 1, 16'h000A, 1'b1, 1, 16'h000A, 1'b1);

        // Asynchronous clear between edges, outputs must drop at once.
        drive(1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
        #2 clr = 1'b0;
        #1 compare("async_clr_a", port_a(0), 17'h0);
        compare("async_clr_b", port_b(0), 17'h0);
        #1 clr = 1'b1;
        cyc("zero_r0_after_reset", 1, 1, 16'h0, 1'b1, 1, 16'h0, 1'b1);
        drive(1'b0, 4'd0, 16'h0, 4'd2, 4'd2);
        cyc("read2_after_clr", 0, 1, 16'h0, 1'b0, 1, 16'h0, 1'b0);

        drive(1'b1, 4'd1, 16'h0003, 4'd0, 4'd0);
        cyc("preload1", 0, 0, 16'h0, 1'b0, 0, 16'h0, 1'b0);
        drive(1'b1, 4'd1, 16'h0005, 4'd1, 4'd1);
        cyc("bypass1", 0, 1, 16'h0005, 1'b1, 1, 16'h0005, 1'b1);
        drive(1'b0, 4'd0, 16'h0, 4'd1, 4'd1);
        cyc("after_bypass1", 0, 1, 16'h0005, 1'b1, 1, 16'h0005, 1'b1);

        fillv = '{4'h1, 4'h2, 4'h3, 4'h4};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'(i), 16'(i + 1), 4'd0, 4'd0);
            cyc("fill", 0, 0, 16'h0, 1'b0, 0, 16'h0, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'd0, 16'h0, 4'(i % 4), 4'((i + 2) % 4));
            cyc($sformatf("hold_rot_%0d", i), 0,
                1, 16'(fillv[i % 4]), 1'b1, 1, 16'(fillv[(i + 2) % 4]), 1'b1);
        end
        drive(1'b1, 4'd3, 16'h000F, 4'd0, 4'd3);
        cyc("write3_bypass_b", 0, 1, 16'h0001, 1'b1, 1, 16'h000F, 1'b1);
        fillv[3] = 4'hF;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'd0, 16'h0, 4'(i), 4'(3 - i));
            cyc($sformatf("only3_changed_%0d", i), 0,
                1, 16'(fillv[i]), 1'b1, 1, 16'(fillv[3 - i]), 1'b1);
        end

        // ZERO_R0 instance shared the fills above: entries 1..3 hold 2,3,F, entry 0 hardwired.
        drive(1'b1, 4'd0, 16'h0007, 4'd0, 4'd0);
        cyc("z_write0_bypass_suppressed", 1, 1, 16'h0, 1'b1, 1, 16'h0, 1'b1);
        drive(1'b0, 4'd0, 16'h0, 4'd0, 4'd2);
        cyc("z_read0_later", 1, 1, 16'h0, 1'b1, 1, 16'h0003, 1'b1);
        drive(1'b0, 4'd0, 16'h0, 4'd0, 4'd3);
        cyc("z_read0_again", 1, 1, 16'h0, 1'b1, 1, 16'h000F, 1'b1);

        // Clear dropped while a write is pending: the write is lost.
        drive(1'b1, 4'd9, 16'hBEEF, 4'd9, 4'd9);
        #2 clr = 1'b0;
        #1 compare("w_clr_mid_write", port_a(2), 17'h0);
        @(negedge clk);
        clr = 1'b1;
        drive(1'b0, 4'd0, 16'h0, 4'd9, 4'd0);
        cyc("w_read9_after_clr", 2, 1, 16'h0, 1'b0, 1, 16'h0, 1'b0);
        drive(1'b1, 4'd9, 16'hBEEF, 4'd0, 4'd9);
        cyc("w_rewrite9", 2, 1, 16'h0, 1'b0, 1, 16'hBEEF, 1'b1);
        drive(1'b1, 4'd15, 16'h1234, 4'd9, 4'd15);
        cyc("w_read9_bypass15", 2, 1, 16'hBEEF, 1'b1, 1, 16'h1234, 1'b1);
        drive(1'b0, 4'd0, 16'h0, 4'd15, 4'd9);
        cyc("w_read15_9", 2, 1, 16'h1234, 1'b1, 1, 16'hBEEF, 1'b1);

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(negedge clk);
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d records left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
